// File: rtl/psum_fifo.sv
// Partial-sum FIFO between PEs: first-word-fall-through, single clock; optional macro PSUM_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.
// Latency: a pushed entry appears on dout one cycle after its push edge; dout of a non-empty FIFO is combinational from storage.
// Backpressure: full blocks pushes unless a pop is accepted in the same cycle; a pop while empty is ignored (no bypass).
module psum_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
`ifdef PSUM_FIFO_ERR_FLAGS_EN
  ,
  output logic                          overflow,
  output logic                          underflow
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  // Pointers carry one wrap bit above the index so equal indices can mean full or empty.
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;
  logic [CW-1:0]         count_nxt;

  // Accept decisions and the next occupancy; a same-cycle pop frees room for a push into a full FIFO.
  always_comb begin
    pop_ok    = pop & ~empty;
    push_ok   = push & (~full | pop_ok);
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - CW'(1);
    end
  end

  // Head entry falls through to the consumer with no read latency.
  assign dout = mem[rd_ptr[AW-1:0]];

  // Storage write; contents are never cleared, only the pointers are.
  always_ff @(posedge clk) begin
    if (reset && !flush && push_ok) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointers, occupancy and registered status flags; flush outranks push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      count       <= count_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == DEPTH_C);
      almost_full <= (count_nxt >= AF_C);
    end
  end

`ifdef PSUM_FIFO_ERR_FLAGS_EN
  // Sticky error flags: a refused push while full, a pop while empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full && !pop_ok) begin
        overflow <= 1'b1;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_psum_fifo.sv
// Bench for psum_fifo: queue-based reference model, per-cycle compare process, directed and random stimulus.
// Inputs change on the falling edge; the model advances after each rising edge; outputs are compared on the falling edge.
// The optional error-flag outputs are checked when PSUM_FIFO_ERR_FLAGS_EN is defined.
module tb_psum_fifo;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [15:0] din = '0;
  logic        full, almost_full, empty;
  logic [15:0] dout;
  logic [3:0]  count;
`ifdef PSUM_FIFO_ERR_FLAGS_EN
  logic        overflow, underflow;
`endif

  psum_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk(clk), .reset(reset), .flush(flush), .push(push), .din(din),
    .full(full), .almost_full(almost_full), .pop(pop), .dout(dout),
    .empty(empty), .count(count)
`ifdef PSUM_FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  int  errors = 0;
  int  checks = 0;
  bit  cmp_en = 1'b0;
  int  q[$];
  bit  m_ovf = 1'b0;
  bit  m_unf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue; flags are derived from its size.
  task automatic model_step();
    bit pop_ok, push_ok;
    if (flush) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      pop_ok  = pop && (q.size() > 0);
      push_ok = push && ((q.size() < DEPTH) || pop_ok);
      if (push && !push_ok) m_ovf = 1'b1;
      if (pop && q.size() == 0) m_unf = 1'b1;
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(int'(din));
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock of stimulus; returns on the following falling edge with inputs idled.
  task automatic cyc(input logic pu, input logic po, input logic fl, input logic [15:0] d);
    push = pu; pop = po; flush = fl; din = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    push = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_count", int'(count), q.size());
      chk("cmp_empty", int'(empty), int'(q.size() == 0));
      chk("cmp_full", int'(full), int'(q.size() == DEPTH));
      chk("cmp_almost_full", int'(almost_full), int'(q.size() >= AF));
      if (q.size() > 0) chk("cmp_dout", int'(dout), q[0]);
`ifdef PSUM_FIFO_ERR_FLAGS_EN
      chk("cmp_overflow", int'(overflow), int'(m_ovf));
      chk("cmp_underflow", int'(underflow), int'(m_unf));
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int wseq[$];
    int rseq[$];
    int pushed, popped, r;
    bit saw_full;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_empty", int'(empty), 1);
    chk("reset_full", int'(full), 0);
    chk("reset_af", int'(almost_full), 0);
    chk("reset_count", int'(count), 0);
    reset = 1'b1;
    cmp_en = 1'b1;

    // Single push of 0x0011, then pop.
    chk("s1_empty_before", int'(empty), 1);
    cyc(1, 0, 0, 16'h0011);
    chk("s1_empty", int'(empty), 0);
    chk("s1_dout", int'(dout), 'h11);
    chk("s1_count", int'(count), 1);
    cyc(0, 1, 0, '0);
    chk("s1_empty_after_pop", int'(empty), 1);
    chk("s1_count_after_pop", int'(count), 0);

    // Fill 1..8, dropped 9th push, drain in order.
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 0, 16'(i));
      if (i == 7) begin
        chk("fill_af_at7", int'(almost_full), 1);
        chk("fill_full_at7", int'(full), 0);
      end
    end
    chk("fill_full_at8", int'(full), 1);
    cyc(1, 0, 0, 16'd9);
    chk("fill_count_after_9th", int'(count), 8);
`ifdef PSUM_FIFO_ERR_FLAGS_EN
    chk("fill_overflow", int'(overflow), 1);
`endif
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", int'(dout), i);
      cyc(0, 1, 0, '0);
    end
    chk("drain_empty", int'(empty), 1);

    // Full FIFO with simultaneous push 0x00AA and pop.
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 16'(8'h10 + i));
    cyc(1, 1, 0, 16'h00AA);
    chk("fullpp_count", int'(count), 8);
    chk("fullpp_head", int'(dout), 'h11);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("fullpp_last", int'(dout), 'hAA);
      cyc(0, 1, 0, '0);
    end

    // Empty FIFO with simultaneous push 0x0005 and pop.
    cyc(1, 1, 0, 16'h0005);
    chk("emptypp_count", int'(count), 1);
    chk("emptypp_dout", int'(dout), 5);
`ifdef PSUM_FIFO_ERR_FLAGS_EN
    chk("emptypp_underflow", int'(underflow), 1);
`endif
    cyc(0, 1, 0, '0);

    // 20 push/pop pairs at random spacing, at most 3 in flight.
    pushed = 0; popped = 0; saw_full = 1'b0;
    for (int n = 0; n < 1000 && popped < 20; n++) begin
      r = $urandom_range(3);
      if (r == 0) begin
        cyc(0, 0, 0, '0);
      end else if (pushed < 20 && q.size() < 3 && (r == 1 || q.size() == 0)) begin
        din = 16'($urandom);
        wseq.push_back(int'(din));
        cyc(1, 0, 0, din);
        pushed++;
      end else if (q.size() > 0) begin
        rseq.push_back(int'(dout));
        cyc(0, 1, 0, '0);
        popped++;
      end else begin
        cyc(0, 0, 0, '0);
      end
      if (full) saw_full = 1'b1;
    end
    chk("pairs_read_count", rseq.size(), 20);
    for (int i = 0; i < 20 && i < rseq.size() && i < wseq.size(); i++)
      chk("pairs_order", rseq[i], wseq[i]);
    chk("pairs_never_full", int'(saw_full), 0);

    // Unconstrained random traffic with occasional flush.
    for (int n = 0; n < 300; n++)
      cyc(1'($urandom_range(99) < 60), 1'($urandom_range(99) < 50),
          1'($urandom_range(99) < 3), 16'($urandom));

    // Five entries stored, then flush with simultaneous push and pop.
    cyc(0, 0, 1, '0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 16'(16'h0100 + i));
    chk("flush_pre_count", int'(count), 5);
    cyc(1, 1, 1, 16'h0BAD);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
`ifdef PSUM_FIFO_ERR_FLAGS_EN
    chk("flush_overflow", int'(overflow), 0);
    chk("flush_underflow", int'(underflow), 0);
`endif

    // Asynchronous reset pulse between edges, then normal operation.
    cyc(1, 0, 0, 16'h0033);
    cyc(1, 0, 0, 16'h0044);
    chk("areset_pre_empty", int'(empty), 0);
    #2 reset = 1'b0;
    #1;
    chk("areset_empty", int'(empty), 1);
    chk("areset_count", int'(count), 0);
    model_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    cyc(1, 0, 0, 16'h0077);
    chk("post_reset_count", int'(count), 1);
    chk("post_reset_dout", int'(dout), 'h77);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psum_fifo.md
PSUM_FIFO -- requirements
Module: psum_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, psum pixel width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, number of entries; legal values are powers of two, 2 to 64.
REQ-003 The block SHALL have parameter AF_LEVEL, default FIFO_DEPTH-1, occupancy at or above which almost_full asserts.
REQ-004 The block SHALL have port clk, input, 1 bit, single clock; all logic rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-006 The block SHALL have port flush, input, 1 bit, synchronous clear of contents.
REQ-007 The block SHALL have port push, input, 1 bit, write request from the upstream PE push_opsum.
REQ-008 The block SHALL have port din, input, DATA_WIDTH bits, write data from the upstream PE opsum_pixel.
REQ-009 The block SHALL have port full, output, 1 bit, to the upstream PE opsum_fifo_full.
REQ-010 The block SHALL have port almost_full, output, 1 bit, count >= AF_LEVEL.
REQ-011 The block SHALL have port pop, input, 1 bit, read request from the downstream PE pop_ipsum.
REQ-012 The block SHALL have port dout, output, DATA_WIDTH bits, head entry, to the downstream PE ipsum_pixel.
REQ-013 The block SHALL have port empty, output, 1 bit, to the downstream PE ipsum_fifo_empty.
REQ-014 The block SHALL have port count, output, clog2(FIFO_DEPTH)+1 bits, current occupancy.

Function
REQ-015 The block SHALL be first-word-fall-through: while empty=0, dout SHALL equal the oldest stored entry combinationally, with no read latency, because the consumer samples dout in the same cycle it asserts pop.
REQ-016 The block SHALL accept a push when push=1 and (full=0 or an accepted pop occurs in the same cycle); an accepted push SHALL write din at the write pointer and advance the pointer modulo FIFO_DEPTH.
REQ-017 The block SHALL accept a pop when pop=1 and empty=0; an accepted pop SHALL advance the read pointer modulo FIFO_DEPTH.
REQ-018 The block SHALL ignore a pop while empty, with no pointer or count change; this includes the cycle of a simultaneous push into an empty FIFO, and there SHALL be no write-to-read bypass.
REQ-019 A push and a pop accepted in the same cycle SHALL leave count unchanged.
REQ-020 A push alone SHALL increment count, and a pop alone SHALL decrement it.
REQ-021 The block SHALL register full, empty and almost_full, derived from the next count: full=(count==FIFO_DEPTH), empty=(count==0).
REQ-022 The block SHALL implement pointers with one extra wrap bit so that full and empty are distinguishable at equal index.
REQ-023 A written entry SHALL become visible on dout, with empty deasserted, in the cycle after its push edge.
REQ-024 flush=1 SHALL, at the next edge, zero both pointers and count, set empty=1 and clear full and almost_full; flush SHALL have priority over push and pop issued in the same cycle, both of which are discarded.
REQ-025 The block SHALL not reset or clear storage contents; dout is don't-care while empty=1.

Reset
REQ-026 reset=0 SHALL immediately, without waiting for a clock edge, force pointers=0, count=0, empty=1, full=0 and almost_full=0, plus error flags=0 when compiled in.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries; push and pop SHALL be ignored while reset=0.
REQ-028 After reset deasserts, the first edge SHALL accept operations normally.

Configuration
REQ-029 The macro PSUM_FIFO_ERR_FLAGS_EN SHALL, when defined, add the outputs overflow and underflow, each 1 bit.
REQ-030 With PSUM_FIFO_ERR_FLAGS_EN, overflow SHALL set on push=1 with full=1 and no accepted pop.
REQ-031 With PSUM_FIFO_ERR_FLAGS_EN, underflow SHALL set on pop=1 with empty=1.
REQ-032 With PSUM_FIFO_ERR_FLAGS_EN, both flags SHALL be sticky and be cleared only by reset or flush.
REQ-033 Without PSUM_FIFO_ERR_FLAGS_EN, the overflow and underflow ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 The bench SHALL cover reset then push 0x0011 once: empty=1 at the push edge, then empty=0, dout=0x0011 and count=1 in the next cycle; pop then gives empty=1 and count=0.
REQ-035 The bench SHALL cover fill with 8 pushes of 1..8 (DEPTH=8): almost_full=1 after the 7th, full=1 after the 8th; a 9th push of 9 is dropped (overflow=1 if enabled); 8 pops return 1..8 in order.
REQ-036 The bench SHALL cover full FIFO with push 0x00AA and pop in the same cycle: count stays 8, the head advances, and 0x00AA is read as the last entry.
REQ-037 The bench SHALL cover an empty FIFO with push 0x0005 and pop in the same cycle: the pop is ignored (underflow=1 if enabled), count=1 and dout=0x0005 in the next cycle.
REQ-038 The bench SHALL cover 20 push/pop pairs at random spacing with a maximum of 3 entries in flight: the read sequence equals the write sequence across the pointer wrap, and full never asserts.
REQ-039 The bench SHALL cover 5 entries stored, then flush with simultaneous push and pop: next cycle count=0, empty=1, flags=0; a later reset=0 pulse between edges drops empty to 1 asynchronously.
